tti_tx_flow: RTL
================

// Module: tti_tx_flow
// PURPOSE
// - Target-side private-read transmitter: TTI TX descriptor + TX data queue -> bus byte stream.
// - Sits between the TTI TX queues and the target bus FSM; counterpart of the RX standby flow.
// - Unpacks 32-bit queue words into bytes, flags the last byte, and drains leftovers on early stop/abort.
// PARAMETERS
// - TxDataWidth   32  TX queue word width; must be 32 (4 bytes/word, little-endian)
// - DescLenWidth  16  width of descriptor byte count
// PORTS
// - clk_i             in   1            clock
// - rst_ni            in   1            async reset, active low
// - enable_i          in   1            block enable; low forces Idle
// - tx_desc_valid_i   in   1            TX descriptor available
// - tx_desc_ready_o   out  1            descriptor pop strobe
// - tx_desc_len_i     in   DescLenWidth byte count of transfer
// - tx_queue_rvalid_i in   1            TX data word available
// - tx_queue_rready_o out  1            TX data word pop strobe
// - tx_queue_rdata_i  in   TxDataWidth  TX data word
// - transfer_start_i  in   1            bus FSM: transfer start pulse
// - transfer_stop_i   in   1            bus FSM: stop/Sr seen
// - transfer_type_i   in   2            00 write, 01 read, 10 CCC
// - tx_abort_i        in   1            controller terminated read (T-bit)
// - tx_byte_valid_o   out  1            byte valid to bus
// - tx_byte_o         out  8            byte to bus
// - tx_byte_last_o    out  1            current byte is last of descriptor
// - tx_byte_ready_i   in   1            bus accepts byte
// - done_o            out  1            1-cycle pulse: transfer finished or drained
// - underrun_o        out  1            1-cycle pulse: byte needed, data/desc missing
// BEHAVIOUR
// - Reset: all outputs 0, state Idle, counters 0.
// - States: Idle -> WaitRead (enable_i) -> LoadDesc (start && type==01) -> Fetch -> Send -> Fetch/Done;
//   Drain on early stop/abort; Done -> WaitRead. enable_i low in any state -> Idle next cycle, no drain.
// - WaitRead: start with type!=01 ignored.
// - LoadDesc: tx_desc_ready_o=1 when tx_desc_valid_i; latch len. No descriptor: underrun_o pulses once,
//   wait; stop while waiting -> WaitRead, no done_o. len==0: Done, no queue pop, no bytes.
// - Fetch: tx_queue_rready_o=1 iff rvalid; word registered, state Send next cycle. Empty: hold,
//   underrun_o pulses once per empty episode; stop/abort -> Drain.
// - Send: byte k = word[8k+7:8k], k=0..3; advance on valid&&ready. tx_byte_o/last stable while valid&&!ready.
//   Last word may be partial: bytes beyond len discarded. last=1 when remaining==1.
//   Words fetched = ceil(len/4); one-cycle bubble between words permitted.
// - Last byte accepted -> Done: done_o=1 for one cycle.
// - Stop/abort before last byte accepted -> Drain: pop remaining unfetched words (wait on rvalid),
//   then done_o; remaining==0 -> done_o next cycle. Abort same cycle as last-byte accept: treat as complete.
// - Byte handshake only in Send; tx_byte_valid_o never asserted in other states.
// CONFIGURATION
// - I3C_TX_BYTE_COUNT_EN defined: extra port tx_bytes_sent_o out DescLenWidth, bytes accepted
//   in current/last transfer; cleared in LoadDesc, holds after done_o.
// - Not defined: port absent, no counter logic; all other behaviour identical.
// TESTING
// - len=6, words 0x44332211,0x88776655, ready=1 -> bytes 11,22,33,44,55,66; last on 66; 2 pops; done_o.
// - len=0 read start -> desc popped, no byte, no word pop, done_o 1 cycle after LoadDesc.
// - len=4, ready toggling 1/0 -> each byte held stable while !ready; order 4 bytes unchanged.
// - len=12, abort after 2nd byte -> Drain pops words 2,3; exactly 3 words popped total; done_o.
// - Read start, TX queue empty 5 cycles -> one underrun_o pulse, valid low, then normal send.
// - type=00 start -> no desc pop; rst_ni low mid-Send -> outputs 0, Idle; I3C_TX_BYTE_COUNT_EN: count=6.

Source files
------------

// File: rtl/tti_tx_flow.sv
// Target-side private-read transmitter: pops a TTI TX descriptor, unpacks 32-bit TX queue words into a byte stream.
// Optional byte counter port tx_bytes_sent_o is built when I3C_TX_BYTE_COUNT_EN is defined.
module tti_tx_flow #(
  parameter int TxDataWidth  = 32,
  parameter int DescLenWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    tx_desc_valid_i,
  output logic                    tx_desc_ready_o,
  input  logic [DescLenWidth-1:0] tx_desc_len_i,
  input  logic                    tx_queue_rvalid_i,
  output logic                    tx_queue_rready_o,
  input  logic [TxDataWidth-1:0]  tx_queue_rdata_i,
  input  logic                    transfer_start_i,
  input  logic                    transfer_stop_i,
  input  logic [1:0]              transfer_type_i,
  input  logic                    tx_abort_i,
  output logic                    tx_byte_valid_o,
  output logic [7:0]              tx_byte_o,
  output logic                    tx_byte_last_o,
  input  logic                    tx_byte_ready_i,
  output logic                    done_o,
  output logic                    underrun_o,
  output logic [2:0]              state_o
`ifdef I3C_TX_BYTE_COUNT_EN
  ,
  output logic [DescLenWidth-1:0] tx_bytes_sent_o
`endif
);

  // Handshakes: a byte moves on a cycle with tx_byte_valid_o && tx_byte_ready_i, and tx_byte_o/last stay
  // stable while valid && !ready; tx_desc_ready_o / tx_queue_rready_o are pop strobes raised only with valid.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_READ = 3'd1,
    S_LOAD_DESC = 3'd2,
    S_FETCH     = 3'd3,
    S_SEND      = 3'd4,
    S_DRAIN     = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [DescLenWidth-1:0] rem_q, rem_d;
  logic [DescLenWidth-1:0] words_q, words_d;
  logic [TxDataWidth-1:0]  word_q, word_d;
  logic [1:0]              idx_q, idx_d;
  logic                    und_seen_q, und_seen_d;
  logic                    stop_any;
  logic [DescLenWidth-1:0] desc_words;

  assign stop_any   = transfer_stop_i | tx_abort_i;
  // Words to fetch = ceil(len/4).
  assign desc_words = {2'b00, tx_desc_len_i[DescLenWidth-1:2]}
                    + {{(DescLenWidth-1){1'b0}}, |tx_desc_len_i[1:0]};
  assign state_o    = state_q;

  always_comb begin
    state_d           = state_q;
    rem_d             = rem_q;
    words_d           = words_q;
    word_d            = word_q;
    idx_d             = idx_q;
    tx_desc_ready_o   = 1'b0;
    tx_queue_rready_o = 1'b0;
    tx_byte_valid_o   = 1'b0;
    tx_byte_o         = 8'h00;
    tx_byte_last_o    = 1'b0;
    done_o            = 1'b0;
    underrun_o        = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_READ;
        S_WAIT_READ: begin
          if (transfer_start_i && transfer_type_i == 2'b01) state_d = S_LOAD_DESC;
        end
        S_LOAD_DESC: begin
          if (tx_desc_valid_i) begin
            tx_desc_ready_o = 1'b1;
            rem_d           = tx_desc_len_i;
            words_d         = desc_words;
            state_d         = (tx_desc_len_i == '0) ? S_DONE : S_FETCH;
          end else if (transfer_stop_i) begin
            state_d = S_WAIT_READ;
          end else begin
            underrun_o = !und_seen_q;
          end
        end
        S_FETCH: begin
          if (stop_any) begin
            state_d = S_DRAIN;
          end else if (tx_queue_rvalid_i) begin
            tx_queue_rready_o = 1'b1;
            word_d            = tx_queue_rdata_i;
            words_d           = words_q - DescLenWidth'(1);
            idx_d             = 2'd0;
            state_d           = S_SEND;
          end else begin
            underrun_o = !und_seen_q;
          end
        end
        S_SEND: begin
          tx_byte_valid_o = 1'b1;
          tx_byte_o       = word_q[{idx_q, 3'b000} +: 8];
          tx_byte_last_o  = (rem_q == DescLenWidth'(1));
          if (tx_byte_ready_i) begin
            rem_d = rem_q - DescLenWidth'(1);
            idx_d = idx_q + 2'd1;
            // Abort in the same cycle as the last byte still counts as a complete transfer.
            if (tx_byte_last_o)  state_d = S_DONE;
            else if (stop_any)   state_d = S_DRAIN;
            else if (idx_q == 2'd3) state_d = S_FETCH;
          end else if (stop_any) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (words_q == '0) begin
            done_o  = 1'b1;
            state_d = S_WAIT_READ;
          end else if (tx_queue_rvalid_i) begin
            tx_queue_rready_o = 1'b1;
            words_d           = words_q - DescLenWidth'(1);
          end
        end
        S_DONE: begin
          done_o  = 1'b1;
          state_d = S_WAIT_READ;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // One underrun pulse per stall episode; re-armed when the state moves on.
    und_seen_d = underrun_o | (und_seen_q & (state_d == state_q));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      words_q    <= '0;
      word_q     <= '0;
      idx_q      <= 2'd0;
      und_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      words_q    <= words_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      und_seen_q <= und_seen_d;
    end
  end

`ifdef I3C_TX_BYTE_COUNT_EN
  logic [DescLenWidth-1:0] sent_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= '0;
    end else if (state_q == S_LOAD_DESC) begin
      sent_q <= '0;
    end else if (tx_byte_valid_o && tx_byte_ready_i) begin
      sent_q <= sent_q + DescLenWidth'(1);
    end
  end

  assign tx_bytes_sent_o = sent_q;
`endif

endmodule
